// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter and related schedulers.
//   arb_state_t : arbiter FSM states (IDLE between grants, GRANT while a producer owns the port)
//   rr_pick()   : round-robin winner search starting just after the last granted index
package fifo_arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  // Widest request vector rr_pick() accepts; callers zero-extend into this width.
  localparam int unsigned MaxReq  = 32;
  localparam int unsigned MaxReqW = 5;

  // Returns the first set bit of req searching from last+1 upward, wrapping modulo num_req.
  // With no request set the result is don't-care (last is returned).
  function automatic int unsigned rr_pick(input logic [MaxReq-1:0] req,
                                          input int unsigned       last,
                                          input int unsigned       num_req);
    int unsigned winner;
    int unsigned idx;
    logic        found;
    winner = last;
    found  = 1'b0;
    for (int unsigned i = 1; i <= MaxReq; i++) begin
      idx = (last + i) % num_req;
      if ((i <= num_req) && !found && req[idx[MaxReqW-1:0]]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
    return winner;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder.
//   req    : request vector, bit k belongs to requester k
//   last   : index granted most recently; search starts at last+1
//   winner : selected index (don't-care when any is low)
//   any    : at least one request is set
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       any
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  logic [MaxReq-1:0] req_wide;

  always_comb begin
    req_wide              = '0;
    req_wide[NUM_REQ-1:0] = req;
  end

  assign winner = IdxW'(rr_pick(req_wide, 32'(last), NUM_REQ));
  assign any    = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one FIFO write port among NUM_REQ producers.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_valid/i_last : per-producer valid and end-of-burst marker
//   i_data         : packed producer data, producer k at [k*SIZE_DATA +: SIZE_DATA]
//   o_ready        : per-producer ready, at most one bit high
//   i_fifo_full    : FIFO full flag; no write is issued while it is high
//   o_fifo_wr_en   : FIFO write enable, o_fifo_data : FIFO write data
//   o_busy         : a producer currently holds the grant
//   o_owner        : current or most recently granted producer
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned SIZE_DATA = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_REQ-1:0]           i_valid,
  input  logic [NUM_REQ-1:0]           i_last,
  input  logic [NUM_REQ*SIZE_DATA-1:0] i_data,
  output logic [NUM_REQ-1:0]           o_ready,
  input  logic                         i_fifo_full,
  output logic                         o_fifo_wr_en,
  output logic [SIZE_DATA-1:0]         o_fifo_data,
  output logic                         o_busy,
  output logic [$clog2(NUM_REQ)-1:0]   o_owner
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(MAX_BURST) + 1;

  arb_state_t      state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] last_grant_q, last_grant_d;
  logic [CntW-1:0] beat_cnt_q, beat_cnt_d;

  logic [IdxW-1:0] pick;
  logic            any_req;
  logic            xfer;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_picker (
    .req    (i_valid),
    .last   (last_grant_q),
    .winner (pick),
    .any    (any_req)
  );

  // Ready depends only on state and full, never on valid, so there is no valid->ready path.
  always_comb begin
    o_ready = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if ((state_q == GRANT) && !i_fifo_full && (owner_q == IdxW'(k))) begin
        o_ready[k] = 1'b1;
      end
    end
  end

  assign xfer         = |(i_valid & o_ready);
  assign o_fifo_wr_en = xfer;
  assign o_busy       = (state_q == GRANT);
  assign o_owner      = owner_q;

  always_comb begin
    o_fifo_data = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (owner_q == IdxW'(k)) begin
        o_fifo_data = i_data[k*SIZE_DATA +: SIZE_DATA];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d    = pick;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        // A full FIFO freezes everything: no beat, no count change, no release.
        if (!i_fifo_full) begin
          if (xfer && !i_last[owner_q] && (beat_cnt_q != CntW'(MAX_BURST - 1))) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end else begin
            // Last beat, burst limit reached, or the owner has gone idle.
            last_grant_d = owner_q;
            state_d      = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_grant_q <= IdxW'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: per-producer beat queues drive the inputs, expected
// FIFO writes are queued by the stimulus and checked by an independent monitor.
module tb_fifo_wr_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [3:0]  i_valid = '0;
  logic [3:0]  i_last = '0;
  logic [31:0] i_data = '0;
  logic [3:0]  o_ready;
  logic        i_fifo_full = 1'b0;
  logic        o_fifo_wr_en;
  logic [7:0]  o_fifo_data;
  logic        o_busy;
  logic [1:0]  o_owner;

  fifo_wr_arbiter #(
    .NUM_REQ   (4),
    .SIZE_DATA (8),
    .MAX_BURST (4)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .i_last       (i_last),
    .i_data       (i_data),
    .o_ready      (o_ready),
    .i_fifo_full  (i_fifo_full),
    .o_fifo_wr_en (o_fifo_wr_en),
    .o_fifo_data  (o_fifo_data),
    .o_busy       (o_busy),
    .o_owner      (o_owner)
  );

  always #5 i_clk = ~i_clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0] owner;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   wr_cyc[$];

  // Producer beat storage: main appends at tl, driver consumes at hd.
  logic [7:0]  pd [4][32];
  logic        pl [4][32];
  int unsigned hd [4] = '{0, 0, 0, 0};
  int unsigned tl [4] = '{0, 0, 0, 0};
  logic [3:0]  fire;

  task automatic load(input int k, input logic [7:0] d, input logic l, input bit expect_it);
    pd[k][tl[k]] = d;
    pl[k][tl[k]] = l;
    tl[k] = tl[k] + 1;
    if (expect_it) exp_q.push_back({2'(k), d});
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int k = 0; k < 4; k++) n += int'(tl[k] - hd[k]);
    return n;
  endfunction

  // Driver: handshake sampled on the falling edge, new beat presented just after the rising edge.
  always begin
    @(negedge i_clk);
    for (int k = 0; k < 4; k++) fire[k] = i_valid[k] & o_ready[k] & i_rst_n;
    @(posedge i_clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (fire[k]) hd[k] = hd[k] + 1;
      if (hd[k] != tl[k]) begin
        i_valid[k]       = 1'b1;
        i_last[k]        = pl[k][hd[k]];
        i_data[k*8 +: 8] = pd[k][hd[k]];
      end else begin
        i_valid[k]       = 1'b0;
        i_last[k]        = 1'b0;
        i_data[k*8 +: 8] = 8'h00;
      end
    end
  end

  // Monitor: every FIFO write is matched against the head of the expected queue.
  always @(negedge i_clk) begin
    exp_t e;
    if (i_rst_n) begin
      if (i_fifo_full) begin
        vectors++;
        if (o_fifo_wr_en !== 1'b0) begin
          miscompares++;
          $display("FAIL wr_while_full: got wr_en %b want 0", o_fifo_wr_en);
        end
      end
      if (o_fifo_wr_en === 1'b1) begin
        wr_cyc.push_back(cyc);
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_write: got owner %0d data %h want no write", o_owner,
                   o_fifo_data);
        end else begin
          e = exp_q.pop_front();
          if ({o_owner, o_fifo_data, o_ready} !== {e.owner, e.data, 4'(4'b0001 << e.owner)}) begin
            miscompares++;
            $display("FAIL write: got owner %0d data %h ready %b want owner %0d data %h",
                     o_owner, o_fifo_data, o_ready, e.owner, e.data);
          end
        end
      end
    end
  end

  task automatic wait_write(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge i_clk);
      if (o_fifo_wr_en === 1'b1) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL %s: got no write within 200 cycles want a write", name);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge i_clk);
      if (exp_q.size() == 0 && o_busy === 1'b0 && pending() == 0) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL %s: got %0d writes outstanding after 300 cycles want 0", name, exp_q.size());
  endtask

  task automatic pulse_reset();
    @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #2 i_rst_n = 1'b1;
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge i_clk);
    #2;
    check("rst_ready", 32'(o_ready), 32'h0);
    check("rst_wr_en", 32'(o_fifo_wr_en), 32'h0);
    check("rst_busy", 32'(o_busy), 32'h0);
    check("rst_owner", 32'(o_owner), 32'h0);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #2;
    check("idle_busy", 32'(o_busy), 32'h0);

    // 1: producer 0, three beats, last on the third; ready one cycle after valid.
    load(0, 8'hA0, 1'b0, 1'b1);
    load(0, 8'hA1, 1'b0, 1'b1);
    load(0, 8'hA2, 1'b1, 1'b1);
    @(posedge i_clk);
    #2;
    check("t1_valid_cycle_ready", 32'(o_ready), 32'h0);
    @(posedge i_clk);
    #2;
    check("t1_grant_cycle_ready", 32'(o_ready), 32'h1);
    wait_drain("t1_drain");
    check("t1_owner", 32'(o_owner), 32'h0);

    // 1b: last_grant is now 0, so producer 1 beats producer 0.
    load(1, 8'hB1, 1'b1, 1'b1);
    load(0, 8'hB0, 1'b1, 1'b1);
    wait_drain("t1b_drain");

    // 2: all four continuously valid, no last: 4-beat bursts in order 0,1,2,3,0.
    pulse_reset();
    wr_cyc.delete();
    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < 4; b++) load(k, 8'((k << 4) + b), 1'b0, 1'b1);
    end
    for (int b = 4; b < 8; b++) load(0, 8'(b), 1'b0, 1'b1);
    wait_drain("t2_drain");
    check("t2_write_count", 32'(wr_cyc.size()), 32'd20);
    if (wr_cyc.size() == 20) begin
      for (int i = 1; i < 20; i++) begin
        check($sformatf("t2_gap_%0d", i), 32'(wr_cyc[i] - wr_cyc[i-1]),
              (i % 4 == 0) ? 32'd2 : 32'd1);
      end
    end

    // 3: producer 2, FIFO full for 5 cycles after beat 1; the burst still ends after 4 beats.
    for (int b = 0; b < 4; b++) load(2, 8'(8'hC0 + b), 1'b0, 1'b1);
    wait_write("t3_beat1");
    @(posedge i_clk);
    #2 i_fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      check($sformatf("t3_stall_ready_%0d", i), 32'(o_ready), 32'h0);
      check($sformatf("t3_stall_busy_%0d", i), 32'(o_busy), 32'h1);
    end
    @(posedge i_clk);
    #2 i_fifo_full = 1'b0;
    wait_write("t3_beat2");
    wait_write("t3_beat3");
    wait_write("t3_beat4");
    @(negedge i_clk);
    check("t3_release_after_4", 32'(o_busy), 32'h0);
    wait_drain("t3_drain");

    // 4: producer 1 drops valid after 2 beats without last; producer 3 wins next.
    load(1, 8'h40, 1'b0, 1'b1);
    load(1, 8'h41, 1'b0, 1'b1);
    wait_write("t4_beat1");
    load(3, 8'h43, 1'b1, 1'b1);
    wait_write("t4_beat2");
    @(negedge i_clk);
    check("t4_idle_cycle_busy", 32'(o_busy), 32'h1);
    check("t4_idle_cycle_valid", 32'(i_valid[1]), 32'h0);
    @(negedge i_clk);
    check("t4_released", 32'(o_busy), 32'h0);
    wait_drain("t4_drain");
    check("t4_owner", 32'(o_owner), 32'h3);

    // 5: reset during beat 2 of producer 2; afterwards producer 0 wins over producer 2.
    load(1, 8'h51, 1'b1, 1'b1);
    wait_drain("t5_pre_drain");
    load(2, 8'h60, 1'b0, 1'b1);
    load(2, 8'h61, 1'b0, 1'b0);
    load(2, 8'h62, 1'b0, 1'b0);
    load(2, 8'h63, 1'b0, 1'b0);
    wait_write("t5_beat1");
    @(posedge i_clk);
    #3 i_rst_n = 1'b0;
    #1;
    check("t5_rst_ready", 32'(o_ready), 32'h0);
    check("t5_rst_wr_en", 32'(o_fifo_wr_en), 32'h0);
    check("t5_rst_busy", 32'(o_busy), 32'h0);
    check("t5_rst_owner", 32'(o_owner), 32'h0);
    load(0, 8'h50, 1'b1, 1'b1);
    exp_q.push_back({2'd2, 8'h61});
    exp_q.push_back({2'd2, 8'h62});
    exp_q.push_back({2'd2, 8'h63});
    repeat (2) @(posedge i_clk);
    #3 i_rst_n = 1'b1;
    wait_drain("t5_drain");

    // 6: only producer 3, with last_grant already 3: the wrapped search still picks 3.
    load(3, 8'h70, 1'b1, 1'b1);
    wait_drain("t6_pre_drain");
    load(3, 8'h71, 1'b1, 1'b1);
    wait_write("t6_beat");
    @(negedge i_clk);
    check("t6_idle_after_single", 32'(o_busy), 32'h0);
    check("t6_owner", 32'(o_owner), 32'h3);
    wait_drain("t6_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running want finished");
    $fatal(1, "timeout");
  end

endmodule
